// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues one outstanding imem request at a time and
// feeds the IF/ID register through a single-entry response buffer.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        branch_taken,
    input  logic [31:0] jump_addr,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        inst_valid_id,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] req_pc_reg;
    logic [31:0] buf_inst_reg;
    logic [31:0] buf_pc_reg;
    logic        buf_valid_reg;
    logic        drop_reg;
    logic [31:0] inst_id_reg;
    logic [31:0] pc_id_reg;
    logic        inst_valid_id_reg;

    logic        redirect;
    logic        req_active;
    logic        accept;
    logic        resp;
    logic        fill;
    logic [31:0] target_pc;

    assign redirect  = branch_taken & clk_en;
    assign target_pc = jump_addr & 32'hFFFF_FFFC;

    // A new request may only go out when the buffer is empty or is being
    // drained into IF/ID on this same edge, so the response always has room.
    assign req_active = (state_reg == ST_REQ) & (~buf_valid_reg | (clk_en & ~flush));
    assign accept     = req_active & imem_gnt;
    assign resp       = (state_reg == ST_WAIT) & imem_rvalid;
    assign fill       = resp & ~drop_reg & ~redirect;

    assign imem_req      = req_active;
    assign imem_addr     = pc_reg;
    assign inst_id       = inst_id_reg;
    assign pc_id         = pc_id_reg;
    assign inst_valid_id = inst_valid_id_reg;
    assign fetch_stall   = ~buf_valid_reg;

    // Fetch FSM, PC and redirect bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
            drop_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_REQ;
                ST_REQ: begin
                    if (accept) begin
                        req_pc_reg <= pc_reg;
                        state_reg  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (redirect) begin
                pc_reg <= target_pc;
            end else if (accept) begin
                pc_reg <= pc_reg + 32'd4;
            end

            // A redirect that coincides with the response discards that very
            // response, so only a still-outstanding one needs to be dropped.
            if (redirect && (((state_reg == ST_WAIT) && !imem_rvalid) || accept)) begin
                drop_reg <= 1'b1;
            end else if (resp) begin
                drop_reg <= 1'b0;
            end
        end
    end

    // Response buffer and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_reg     <= 1'b0;
            buf_inst_reg      <= NOP_INST;
            buf_pc_reg        <= 32'h0000_0000;
            inst_id_reg       <= NOP_INST;
            pc_id_reg         <= 32'h0000_0000;
            inst_valid_id_reg <= 1'b0;
        end else begin
            if (fill) begin
                buf_inst_reg <= imem_rdata;
                buf_pc_reg   <= req_pc_reg;
            end

            if (redirect) begin
                buf_valid_reg <= 1'b0;
            end else if (fill) begin
                buf_valid_reg <= 1'b1;
            end else if (clk_en && !flush) begin
                buf_valid_reg <= 1'b0;
            end

            if (redirect || flush) begin
                inst_id_reg       <= NOP_INST;
                inst_valid_id_reg <= 1'b0;
            end else if (clk_en) begin
                if (buf_valid_reg) begin
                    inst_id_reg       <= buf_inst_reg;
                    pc_id_reg         <= buf_pc_reg;
                    inst_valid_id_reg <= 1'b1;
                end else begin
                    inst_id_reg       <= NOP_INST;
                    inst_valid_id_reg <= 1'b0;
                end
            end
        end
    end

endmodule
